// File: rtl/dec_serializer_mc.sv
// dec_serializer_mc: multi-channel parallel-to-serial frame serializer.
// An asynchronous valid_strobe rise loads all N_CH words of data_i; the words
// are shifted out MSB first, channel 0 first, each bit held BIT_DIV clocks.
// Optional feature macro: DEC_SER_PARITY_EN appends one even-parity bit
// after every channel word.
module dec_serializer_mc #(
  parameter int DATA_W  = 22,
  parameter int N_CH    = 2,
  parameter int BIT_DIV = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   valid_strobe,
  input  logic [N_CH*DATA_W-1:0]                 data_i,
  input  logic                                   ovr_clr,
  output logic                                   data_o,
  output logic                                   frame_sync,
  output logic                                   ch_sync,
  output logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] ch_idx,
  output logic                                   busy,
  output logic                                   overrun
);

  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
`ifdef DEC_SER_PARITY_EN
  localparam int PAR     = 1;
`else
  localparam int PAR     = 0;
`endif
  // Bit slots per channel word: data bits plus the optional parity slot.
  localparam int SLOTS   = DATA_W + PAR;
  localparam int SLOT_W  = $clog2(SLOTS);
  localparam int DIV_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int FRAME_W = N_CH * DATA_W;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q;
  logic [2:0]          sync_q;   // [0]=stage1, [1]=stage2, [2]=stage3
  logic [1:0]          warm_q;
  logic                armed_q;
  logic [DIV_W-1:0]    div_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [DATA_W-1:0]   word_q;   // remaining bits of the current word, next bit at MSB
  logic [FRAME_W-1:0]  rest_q;   // words not yet started, next one in the low bits
`ifdef DEC_SER_PARITY_EN
  logic                par_q;    // even parity of the current word
`endif

  logic load_req;
  logic period_end;
  logic word_end;
  logic frame_end;

  // Strobe synchronizer plus an arm flag that blocks a strobe held across reset release.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every clocked register is assigned with <= so all flops sample the
    // pre-edge values; a blocking = here would turn the chain into one wire.
    if (rst) begin
      sync_q  <= '0;
      warm_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], valid_strobe};
      warm_q <= {warm_q[0], 1'b1};
      // NOTE: stage2 is only trusted once two post-reset samples have flowed
      // in; arming on a genuine low level means a high strobe across release
      // never looks like a fresh rise.
      if (warm_q[1] && !sync_q[1]) armed_q <= 1'b1;
    end
  end

  assign load_req   = sync_q[1] & ~sync_q[2] & armed_q;
  assign period_end = (div_q == DIV_W'(BIT_DIV - 1));
  assign word_end   = period_end && (slot_q == SLOT_W'(SLOTS - 1));
  assign frame_end  = word_end && (ch_idx == CH_W'(N_CH - 1));

  // Frame FSM with registered serial outputs and the sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      slot_q     <= '0;
      word_q     <= '0;
      rest_q     <= '0;
`ifdef DEC_SER_PARITY_EN
      par_q      <= 1'b0;
`endif
      data_o     <= 1'b0;
      frame_sync <= 1'b0;
      ch_sync    <= 1'b0;
      ch_idx     <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // A request that finds a frame running (including its last cycle) is
      // dropped and flagged; setting wins over a coincident clear.
      if (load_req && state_q == SHIFT) overrun <= 1'b1;
      else if (ovr_clr)                 overrun <= 1'b0;

      if (state_q == IDLE) begin
        if (load_req) begin
          state_q    <= SHIFT;
          busy       <= 1'b1;
          frame_sync <= 1'b1;
          ch_sync    <= 1'b1;
          ch_idx     <= '0;
          div_q      <= '0;
          slot_q     <= '0;
          data_o     <= data_i[DATA_W-1];
          word_q     <= data_i[DATA_W-1:0] << 1;
          rest_q     <= data_i >> DATA_W;
`ifdef DEC_SER_PARITY_EN
          par_q      <= ^data_i[DATA_W-1:0];
`endif
        end
      end else if (!period_end) begin
        div_q <= div_q + DIV_W'(1);
      end else begin
        div_q <= '0;
        if (frame_end) begin
          state_q    <= IDLE;
          busy       <= 1'b0;
          frame_sync <= 1'b0;
          ch_sync    <= 1'b0;
          ch_idx     <= '0;
          slot_q     <= '0;
          data_o     <= 1'b0;
        end else if (word_end) begin
          ch_idx     <= ch_idx + CH_W'(1);
          slot_q     <= '0;
          ch_sync    <= 1'b1;
          data_o     <= rest_q[DATA_W-1];
          word_q     <= rest_q[DATA_W-1:0] << 1;
          rest_q     <= rest_q >> DATA_W;
`ifdef DEC_SER_PARITY_EN
          par_q      <= ^rest_q[DATA_W-1:0];
`endif
        end else begin
          slot_q     <= slot_q + SLOT_W'(1);
          ch_sync    <= 1'b0;
`ifdef DEC_SER_PARITY_EN
          if (slot_q == SLOT_W'(DATA_W - 1)) begin
            data_o   <= par_q;
          end else begin
            data_o   <= word_q[DATA_W-1];
            word_q   <= word_q << 1;
          end
`else
          data_o     <= word_q[DATA_W-1];
          word_q     <= word_q << 1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_dec_serializer_mc.sv
// Testbench for dec_serializer_mc: two instances (BIT_DIV=1 and BIT_DIV=4)
// share one stimulus stream; a frame-level model predicts every output on
// every cycle, and directed literal checks pin latency, lengths and patterns.
// Honours DEC_SER_PARITY_EN when the RTL is built with it.
`timescale 1ns/1ps
module tb_dec_serializer_mc;

  localparam int DATA_W = 22;
  localparam int N_CH   = 2;
`ifdef DEC_SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int S  = DATA_W + P;   // slots per word
  localparam int F1 = N_CH * S;     // frame length, BIT_DIV=1
  localparam int F4 = F1 * 4;       // frame length, BIT_DIV=4

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     valid_strobe;
  logic                     ovr_clr;
  logic [N_CH*DATA_W-1:0]   data_i;
  logic                     dout  [2];
  logic                     fsync [2];
  logic                     csync [2];
  logic                     cidx  [2];
  logic                     bsy   [2];
  logic                     ovr   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_serializer_mc #(.DATA_W(DATA_W), .N_CH(N_CH), .BIT_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .valid_strobe(valid_strobe), .data_i(data_i),
    .ovr_clr(ovr_clr), .data_o(dout[0]), .frame_sync(fsync[0]),
    .ch_sync(csync[0]), .ch_idx(cidx[0]), .busy(bsy[0]), .overrun(ovr[0])
  );

  dec_serializer_mc #(.DATA_W(DATA_W), .N_CH(N_CH), .BIT_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .valid_strobe(valid_strobe), .data_i(data_i),
    .ovr_clr(ovr_clr), .data_o(dout[1]), .frame_sync(fsync[1]),
    .ch_sync(csync[1]), .ch_idx(cidx[1]), .busy(bsy[1]), .overrun(ovr[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- frame-level model ----------------
  // pos = cycle index within the running frame, -1 when idle.
  int                     pos [2] = '{-1, -1};
  logic [N_CH*DATA_W-1:0] cap [2];
  bit                     movr [2];
  bit                     pipe0, pipe1, have_prev, prev_s;
  bit                     m_req, m_rise, m_act;

  function automatic int flen(input int i);
    return (i == 0) ? F1 : F4;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          pos[i]  = -1;
          movr[i] = 1'b0;
        end
        pipe0 = 0; pipe1 = 0; have_prev = 0; prev_s = 0;
      end else begin
        // A rise seen at this edge loads two edges later.
        m_req     = pipe1;
        m_rise    = have_prev && !prev_s && (valid_strobe === 1'b1);
        pipe1     = pipe0;
        pipe0     = m_rise;
        prev_s    = (valid_strobe === 1'b1);
        have_prev = 1;
        for (int i = 0; i < 2; i++) begin
          m_act = (pos[i] >= 0);
          if (m_act) begin
            pos[i]++;
            if (pos[i] == flen(i)) pos[i] = -1;
          end
          if (m_req && m_act) begin
            movr[i] = 1'b1;
          end else begin
            if (m_req) begin
              pos[i] = 0;
              cap[i] = data_i;
            end
            if (ovr_clr) movr[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic model_out(input int i, output logic e_d, output logic e_fs,
                           output logic e_cs, output logic e_ci);
    int d, b, w, s;
    logic [DATA_W-1:0] word;
    e_d = 0; e_fs = 0; e_cs = 0; e_ci = 0;
    if (pos[i] >= 0) begin
      d    = (i == 0) ? 1 : 4;
      b    = pos[i] / d;
      w    = b / S;
      s    = b % S;
      word = cap[i][w*DATA_W +: DATA_W];
      e_d  = (s < DATA_W) ? word[DATA_W-1-s] : ^word;
      e_fs = 1'b1;
      e_cs = (s == 0);
      e_ci = w[0];
    end
  endtask

  // Compare process: every negedge outside reset, both instances.
  initial begin
    logic e_d, e_fs, e_cs, e_ci;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        for (int i = 0; i < 2; i++) begin
          model_out(i, e_d, e_fs, e_cs, e_ci);
          check($sformatf("dut%0d data_o", i),     64'(dout[i]),  64'(e_d));
          check($sformatf("dut%0d frame_sync", i), 64'(fsync[i]), 64'(e_fs));
          check($sformatf("dut%0d ch_sync", i),    64'(csync[i]), 64'(e_cs));
          check($sformatf("dut%0d ch_idx", i),     64'(cidx[i]),  64'(e_ci));
          check($sformatf("dut%0d busy", i),       64'(bsy[i]),   64'(e_fs));
          check($sformatf("dut%0d overrun", i),    64'(ovr[i]),   64'(movr[i]));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [63:0] seq;
  logic [63:0] exp_seq;
  int          nb0, nb1, ncs, first_tr;
  int          cs_pos [2];
  logic        ci_first, ci_second, d4_first;

  initial begin
    rst = 1'b1; valid_strobe = 1'b0; ovr_clr = 1'b0; data_i = '0;
    #3;
    for (int i = 0; i < 2; i++)
      check($sformatf("dut%0d outputs in reset", i),
            64'({dout[i], fsync[i], csync[i], cidx[i], bsy[i], ovr[i]}), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(3);

    // ---- Frame A: pattern, lengths, latency ----
    data_i = {22'h000001, 22'h2AAAAA};
    valid_strobe = 1'b1;
    tick(1); check("no load after edge k",   64'({bsy[0], bsy[1]}), 64'd0);
    tick(1); check("no load after edge k+1", 64'({bsy[0], bsy[1]}), 64'd0);
    tick(1);
    check("load at edge k+2 busy",    64'({bsy[0], bsy[1]}),     64'b11);
    check("load ch_sync",             64'({csync[0], csync[1]}), 64'b11);
    check("load first bit is MSB",    64'({dout[0], dout[1]}),   64'b11);
    seq = '0; nb0 = 0; nb1 = 0; ncs = 0; first_tr = -1;
    cs_pos[0] = -1; cs_pos[1] = -1; ci_first = 1'b1; ci_second = 1'b0;
    d4_first = dout[1];
    for (int c = 0; c < 200; c++) begin
      if (c == 2) valid_strobe = 1'b0;
      if (c == 5) data_i = {22'h15555, 22'h3FFFFF};
      if (bsy[0]) begin
        seq = {seq[62:0], dout[0]};
        nb0++;
        if (csync[0]) begin
          if (ncs < 2) cs_pos[ncs] = c;
          ncs++;
        end
        if (c == 0) ci_first  = cidx[0];
        if (c == S) ci_second = cidx[0];
      end
      if (bsy[1]) nb1++;
      if (c > 0 && first_tr < 0 && dout[1] !== d4_first) first_tr = c;
      tick(1);
    end
`ifdef DEC_SER_PARITY_EN
    exp_seq = 64'({22'h2AAAAA, 1'b1, 22'h000001, 1'b1});
`else
    exp_seq = 64'({22'h2AAAAA, 22'h000001});
`endif
    check("frame A serial pattern",     seq,                exp_seq);
    check("frame A busy cycles div1",   64'(nb0),           64'(F1));
    check("frame A busy cycles div4",   64'(nb1),           64'(F4));
    check("frame A ch_sync count",      64'(ncs),           64'd2);
    check("frame A ch_sync pos 0",      64'(cs_pos[0]),     64'd0);
    check("frame A ch_sync pos 1",      64'(cs_pos[1]),     64'(S));
    check("frame A ch_idx first word",  64'(ci_first),      64'd0);
    check("frame A ch_idx second word", 64'(ci_second),     64'd1);
    check("div4 first transition",      64'(first_tr),      64'd4);
    check("frame A no overrun",         64'({ovr[0], ovr[1]}), 64'd0);

`ifdef DEC_SER_PARITY_EN
    // ---- Parity frame ----
    data_i = {22'h000003, 22'h000007};
    valid_strobe = 1'b1;
    tick(3);
    nb0 = 0;
    for (int c = 0; c < 200; c++) begin
      if (c == 2) valid_strobe = 1'b0;
      if (bsy[0]) nb0++;
      if (c == 22) check("parity bit ch0", 64'(dout[0]), 64'd1);
      if (c == 45) check("parity bit ch1", 64'(dout[0]), 64'd0);
      tick(1);
    end
    check("parity frame length", 64'(nb0), 64'd46);
`endif

    // ---- Frame B: overrun set, clear, set-beats-clear ----
    data_i = {22'h0F0F0F, 22'h155555};
    valid_strobe = 1'b1;
    tick(3);
    for (int c = 0; c < 200; c++) begin
      if (c == 2)  valid_strobe = 1'b0;
      if (c == 8)  valid_strobe = 1'b1;
      if (c == 12) valid_strobe = 1'b0;
      if (c == 20) begin
        check("overrun set mid-frame", 64'({ovr[0], ovr[1]}), 64'b11);
        ovr_clr = 1'b1;
      end
      if (c == 21) begin
        ovr_clr = 1'b0;
        check("overrun cleared", 64'({ovr[0], ovr[1]}), 64'd0);
      end
      if (c == 25) valid_strobe = 1'b1;
      if (c == 27) ovr_clr = 1'b1;
      if (c == 28) begin
        ovr_clr = 1'b0;
        valid_strobe = 1'b0;
        check("overrun set beats clear", 64'({ovr[0], ovr[1]}), 64'b11);
      end
      if (c == 30) ovr_clr = 1'b1;
      if (c == 31) begin
        ovr_clr = 1'b0;
        check("overrun cleared again", 64'({ovr[0], ovr[1]}), 64'd0);
      end
      tick(1);
    end

    // ---- Frame C: request on the final bit period is dropped ----
    data_i = {22'h000002, 22'h000003};
    valid_strobe = 1'b1;
    tick(3);
    for (int c = 0; c < 200; c++) begin
      if (c == 2)      valid_strobe = 1'b0;
      if (c == F1 - 3) valid_strobe = 1'b1;
      if (c == F1 - 1) valid_strobe = 1'b0;
      if (c == F1 + 2) begin
        check("frame-end request dropped", 64'(bsy[0]), 64'd0);
        check("frame-end request overrun", 64'(ovr[0]), 64'd1);
      end
      if (c == 190) ovr_clr = 1'b1;
      if (c == 191) ovr_clr = 1'b0;
      tick(1);
    end

    // ---- Frame D: reset mid-frame, strobe held across release ----
    data_i = {22'h001234, 22'h03ABCD};
    valid_strobe = 1'b1;
    tick(3);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) valid_strobe = 1'b0;
      tick(1);
    end
    valid_strobe = 1'b1;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("dut%0d outputs on async reset", i),
            64'({dout[i], fsync[i], csync[i], cidx[i], bsy[i], ovr[i]}), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(12);
    check("held strobe after reset no load", 64'({bsy[0], bsy[1]}), 64'd0);
    valid_strobe = 1'b0;
    tick(4);
    valid_strobe = 1'b1;
    tick(1); check("fresh rise edge k",   64'({bsy[0], bsy[1]}), 64'd0);
    tick(1); check("fresh rise edge k+1", 64'({bsy[0], bsy[1]}), 64'd0);
    tick(1); check("fresh rise loads",    64'({bsy[0], bsy[1]}), 64'b11);
    tick(2);
    valid_strobe = 1'b0;
    tick(200);
    check("idle after final frame", 64'({bsy[0], bsy[1]}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
